// File: rtl/uart_cfg_top.sv
// Parametrised full-duplex UART: shared 16x tick, TX serializer, RX with majority vote.
// Optional parity bit logic is built only when UART_PARITY_EN is defined.
module uart_cfg_top #(
  parameter int CLOCK_FREQ = 1_000_000,
  parameter int BAUD_RATE  = 10_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [4:0] STOP_END = 5'(16 * STOP_BITS - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN  = (PARITY != 0);
  localparam bit PAR_ODD = (PARITY == 1);
`endif

  if (DIV < 1) begin : g_div_chk
    $error("uart_cfg_top: CLOCK_FREQ too low for BAUD_RATE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_cfg_top: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_cfg_top: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_cfg_top: PARITY must be 0..2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;

  // free-running divider, one-clock tick every DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  state_t                tx_st;
  logic [4:0]            tx_cnt;
  logic [3:0]            tx_idx;
  logic [DATA_BITS-1:0]  tx_sh;
  logic                  tx_lead;
`ifdef UART_PARITY_EN
  logic                  tx_par;
`endif

  // TX: start bit waits for the next tick, then each state lasts 16 ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st     <= S_IDLE;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_sh     <= '0;
      tx_lead   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (tx_st)
        S_IDLE: begin
          tx_busy <= 1'b0;
          if (tx_start && !tx_busy) begin
            tx_busy <= 1'b1;
            tx_sh   <= tx_data;
            tx_lead <= 1'b1;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_st   <= S_START;
`ifdef UART_PARITY_EN
            tx_par  <= PAR_ODD ? ~^tx_data : ^tx_data;
`endif
          end
        end
        S_START: if (tick) begin
          if (tx_lead) begin
            tx_lead   <= 1'b0;
            tx_serial <= 1'b0;
          end else if (tx_cnt == 5'd15) begin
            tx_cnt    <= '0;
            tx_st     <= S_DATA;
            tx_serial <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + 5'd1;
          end
        end
        S_DATA: if (tick) begin
          if (tx_cnt == 5'd15) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
              if (PAR_EN) begin
                tx_st     <= S_PAR;
                tx_serial <= tx_par;
              end else begin
                tx_st     <= S_STOP;
                tx_serial <= 1'b1;
              end
`else
              tx_st     <= S_STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              tx_idx    <= tx_idx + 4'd1;
              tx_sh     <= tx_sh >> 1;
              tx_serial <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 5'd1;
          end
        end
        S_PAR: if (tick) begin
          if (tx_cnt == 5'd15) begin
            tx_cnt    <= '0;
            tx_st     <= S_STOP;
            tx_serial <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 5'd1;
          end
        end
        S_STOP: if (tick) begin
          if (tx_cnt == STOP_END) begin
            tx_cnt  <= '0;
            tx_st   <= S_IDLE;
            tx_done <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 5'd1;
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  logic s1, s2, s3;

  // two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx_serial;
      s2 <= s1;
      s3 <= s2;
    end
  end

  state_t               rx_st;
  logic [3:0]           rx_cnt;
  logic [3:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 m7, m8;
  logic                 rx_maj;
`ifdef UART_PARITY_EN
  logic                 rx_perr;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_maj = (m7 & m8) | (m7 & s2) | (m8 & s2);

  // RX: phase counter from start edge, vote at ticks 7/8/9, decide on tick 9
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st        <= S_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_sh        <= '0;
      m7           <= 1'b1;
      m8           <= 1'b1;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_ready <= 1'b0;
      if (tick && rx_cnt == 4'd7) m7 <= s2;
      if (tick && rx_cnt == 4'd8) m8 <= s2;
      unique case (rx_st)
        S_IDLE: begin
`ifdef UART_PARITY_EN
          rx_perr <= 1'b0;
`endif
          if (s3 && !s2) begin
            rx_st  <= S_START;
            rx_cnt <= '0;
            rx_idx <= '0;
          end
        end
        S_START: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd8 && s2) rx_st <= S_IDLE;
          else if (rx_cnt == 4'd15) rx_st <= S_DATA;
        end
        S_DATA: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd9) rx_sh <= {rx_maj, rx_sh[DATA_BITS-1:1]};
          if (rx_cnt == 4'd15) begin
            if (rx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_st <= PAR_EN ? S_PAR : S_STOP;
`else
              rx_st <= S_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + 4'd1;
            end
          end
        end
        S_PAR: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
`ifdef UART_PARITY_EN
          if (rx_cnt == 4'd9)
            rx_perr <= rx_maj ^ (PAR_ODD ? ~^rx_sh : ^rx_sh);
`endif
          if (rx_cnt == 4'd15) rx_st <= S_STOP;
        end
        S_STOP: if (tick) begin
          rx_cnt <= rx_cnt + 4'd1;
          if (rx_cnt == 4'd9) begin
            rx_st        <= S_IDLE;
            rx_data      <= rx_sh;
            rx_frame_err <= !rx_maj;
            rx_ready     <= 1'b1;
`ifdef UART_PARITY_EN
            rx_parity_err <= rx_perr;
`endif
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_top.sv
// Loopback and line-driven checks of uart_cfg_top at DIV=10 (160 clks/bit).
// Frame format follows UART_PARITY_EN: 9E2 when defined, 8N1 otherwise.
module tb_uart_cfg_top;

`ifdef UART_PARITY_EN
  localparam int DB  = 9;
  localparam int PAR = 2;
  localparam int SB  = 2;
`else
  localparam int DB  = 8;
  localparam int PAR = 0;
  localparam int SB  = 1;
`endif
  localparam int PB   = (PAR != 0) ? 1 : 0;
  localparam int DIV  = 10;
  localparam int BITC = 160;
  localparam int FR   = (1 + DB + PB + SB) * BITC;

  logic clk = 1'b0;
  logic rst_n, tx_start, rx_serial;
  logic tx_serial, tx_busy, tx_done;
  logic rx_ready, rx_frame_err, rx_parity_err;
  logic [DB-1:0] tx_data, rx_data;
  logic loop, drv;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  logic [DB-1:0] mon_data = '0;
  logic mon_fe = 1'b0;
  logic mon_pe = 1'b0;

  uart_cfg_top #(
    .CLOCK_FREQ(1_600_000),
    .BAUD_RATE (10_000),
    .DATA_BITS (DB),
    .PARITY    (PAR),
    .STOP_BITS (SB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_serial    (tx_serial),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  assign rx_serial = loop ? tx_serial : drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_ready) begin
      rdy_cnt++;
      mon_data = rx_data;
      mon_fe   = rx_frame_err;
      mon_pe   = rx_parity_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v,
                         input int lo, input int hi);
    tests++;
    assert (v >= lo && v <= hi) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  function automatic logic par_bit(input logic [DB-1:0] d);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    if (PAR == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  task automatic send_line(input logic [DB-1:0] d, input int bc,
                           input logic flip, input logic stop_lvl);
    drv = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      drv = d[i];
      repeat (bc) @(negedge clk);
    end
    if (PB != 0) begin
      drv = par_bit(d) ^ flip;
      repeat (bc) @(negedge clk);
    end
    drv = stop_lvl;
    repeat (bc) @(negedge clk);
    drv = 1'b1;
    if (SB == 2) repeat (bc) @(negedge clk);
  endtask

  task automatic wait_rdy(input int r0, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 3 * BITC; k++) begin
      if (rdy_cnt != r0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic line_case(input string tag, input logic [DB-1:0] d,
                           input int bc, input logic flip,
                           input logic stop_lvl, input logic efe,
                           input logic epe);
    int r0;
    logic ok;
    r0 = rdy_cnt;
    send_line(d, bc, flip, stop_lvl);
    wait_rdy(r0, ok);
    chk({tag, "_rdy"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, 32'(mon_data), 32'(d));
    chk({tag, "_fe"}, 32'(mon_fe), 32'(efe));
    chk({tag, "_pe"}, 32'(mon_pe), 32'(epe));
    repeat (2 * BITC) @(negedge clk);
  endtask

  task automatic tx_case(input string tag, input logic [DB-1:0] d,
                         input logic inj);
    int r0, ta, te, td;
    logic b1, ok;
    r0 = rdy_cnt;
    te = -1;
    td = -1;
    b1 = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    ta = cyc;
    for (int k = 0; k < 4 * DIV; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (k == 0) b1 = tx_busy;
      if (!tx_serial) begin
        te = cyc;
        break;
      end
    end
    chk({tag, "_busy"}, 32'(b1), 32'd1);
    chk_rng({tag, "_lat"}, te - ta, 2, DIV + 2);
    for (int k = 0; k < FR + 4 * BITC; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (tx_done) begin
        td = cyc;
        if (inj) begin
          tx_data  = '1;
          tx_start = 1'b1;
        end
        break;
      end
      if (inj && k == 500) begin
        tx_data  = '1;
        tx_start = 1'b1;
      end
    end
    chk_rng({tag, "_len"}, td - te, FR - 10, FR + 10);
    wait_rdy(r0, ok);
    tx_start = 1'b0;
    chk({tag, "_rdy"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, 32'(mon_data), 32'(d));
    chk({tag, "_fe"}, 32'(mon_fe), 32'd0);
    chk({tag, "_pe"}, 32'(mon_pe), 32'd0);
    if (inj) begin
      chk({tag, "_ignored"}, 32'(tx_busy), 32'd0);
      repeat (2 * BITC) @(negedge clk);
      chk({tag, "_nofrm"}, 32'(rdy_cnt), 32'(r0 + 1));
    end
  endtask

  initial begin
    int r0;
    logic [DB-1:0] rv;
    logic [31:0] dir [5];
    dir = '{32'h08, 32'h31, 32'h69, 32'h23, 32'hBB};

    rst_n    = 1'b0;
    loop     = 1'b1;
    drv      = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_txs", 32'(tx_serial), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_rdy", 32'(rx_ready), 32'd0);
    chk("rst_fe", 32'(rx_frame_err), 32'd0);
    chk("rst_pe", 32'(rx_parity_err), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (dir[i]) tx_case($sformatf("dir%0d", i), DB'(dir[i]), 1'b0);

`ifdef UART_PARITY_EN
    tx_case("p1a5", DB'(32'h1A5), 1'b0);
    loop = 1'b0;
    repeat (BITC) @(negedge clk);
    line_case("pflip", DB'(32'h1A5), BITC, 1'b1, 1'b1, 1'b0, 1'b1);
    line_case("pgood", DB'(32'h0F3), BITC, 1'b0, 1'b1, 1'b0, 1'b0);
    loop = 1'b1;
`endif

    repeat (4) tx_case("rnd", DB'($urandom), 1'b0);
    tx_case("inj", DB'($urandom_range(0, 254)), 1'b1);

    loop = 1'b0;
    repeat (BITC) @(negedge clk);
    line_case("ferr", DB'(32'h55), BITC, 1'b0, 1'b0, 1'b1, 1'b0);
    line_case("fclr", DB'(32'hAA), BITC, 1'b0, 1'b1, 1'b0, 1'b0);

    r0 = rdy_cnt;
    drv = 1'b0;
    repeat (60) @(negedge clk);
    drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch", 32'(rdy_cnt), 32'(r0));
    line_case("postgl", DB'($urandom), BITC, 1'b0, 1'b1, 1'b0, 1'b0);

    line_case("skfast", DB'(32'hC3), 155, 1'b0, 1'b1, 1'b0, 1'b0);
    line_case("skslow", DB'(32'hC3), 165, 1'b0, 1'b1, 1'b0, 1'b0);
    line_case("skrnd", DB'($urandom), 155, 1'b0, 1'b1, 1'b0, 1'b0);

    r0 = rdy_cnt;
    drv = 1'b0;
    repeat ((3 + DB + PB + SB) * BITC) @(negedge clk);
    chk("brk_cnt", 32'(rdy_cnt), 32'(r0 + 1));
    chk("brk_data", 32'(mon_data), 32'd0);
    chk("brk_fe", 32'(mon_fe), 32'd1);
    drv = 1'b1;
    repeat (2 * BITC) @(negedge clk);
    chk("brk_wait", 32'(rdy_cnt), 32'(r0 + 1));
    rv = DB'($urandom);
    line_case("postbrk", rv, BITC, 1'b0, 1'b1, 1'b0, 1'b0);

    loop = 1'b1;
    @(negedge clk);
    tx_data  = DB'($urandom);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * BITC) @(negedge clk);
    r0 = rdy_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstm_txs", 32'(tx_serial), 32'd1);
    chk("rstm_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("rstm_nordy", 32'(rdy_cnt), 32'(r0));
    tx_case("post3c", DB'(32'h3C), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
